// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the FSM encoding, the default byte width and the index-width helper.
package uart_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  localparam int DEFAULT_DATA_W = 8;

  // A single requester still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning cyclically from the pointer.
// Returns the winner as a one-hot vector and as a binary index.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [IDX_W-1:0]   o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        o_idx         = w_idx;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources, one whole message
// per grant, round-robin between messages, with an idle timeout on the owner.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_busy,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      new_tx,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(IDLE_TIMEOUT);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]      r_owner, w_owner_nxt;
  logic [IW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [TW-1:0]      r_timer, w_timer_nxt;
  logic               r_new_tx, w_new_tx_nxt;
  logic [DATA_W-1:0]  r_tx_data, w_tx_data_nxt;

  logic [NUM_REQ-1:0] w_pick;
  logic [IW-1:0]      w_pick_idx;
  logic [DATA_W-1:0]  w_owner_data;
  logic               w_accept;
  logic               w_release;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IW)
  ) u_rr_pick (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_pick(w_pick),
    .o_idx (w_pick_idx)
  );

  // The new_tx term covers the UART's one-cycle lag before it raises tx_busy.
  assign req_busy     = ~(r_grant & {NUM_REQ{~tx_busy & ~r_new_tx}});
  assign w_owner_data = req_data[int'(r_owner)*DATA_W +: DATA_W];
  assign w_accept     = (r_state == GRANTED) && req_valid[r_owner] && !req_busy[r_owner];

  assign grant   = r_grant;
  assign new_tx  = r_new_tx;
  assign tx_data = r_tx_data;

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_timer_nxt   = r_timer;
    w_new_tx_nxt  = 1'b0;
    w_tx_data_nxt = r_tx_data;
    w_release     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt = GRANTED;
          w_grant_nxt = w_pick;
          w_owner_nxt = w_pick_idx;
          w_timer_nxt = '0;
        end
      end
      GRANTED: begin
        // An accept always wins over a stall timeout or a dropped request.
        if (w_accept) begin
          w_new_tx_nxt  = 1'b1;
          w_tx_data_nxt = w_owner_data;
          w_timer_nxt   = '0;
          w_release     = req_last[r_owner];
        end else begin
          w_release = !req[r_owner] || (r_timer == TIMER_LAST);
          if (r_timer != TIMER_MAX) w_timer_nxt = r_timer + 1'b1;
        end
        if (w_release) begin
          w_state_nxt  = IDLE;
          w_grant_nxt  = '0;
          w_timer_nxt  = '0;
          w_rr_ptr_nxt = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_timer   <= '0;
      r_new_tx  <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_timer   <= w_timer_nxt;
      r_new_tx  <= w_new_tx_nxt;
      r_tx_data <= w_tx_data_nxt;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between NUM_REQ byte-stream sources, such as the greeting generator and an echo path, so that each message goes out uninterrupted. Round-robin arbitration runs per message: a granted source owns the transmitter until it flags its last byte, drops its request, or stalls past a timeout. The block sits between the sources and the UART tx. Toward the UART it uses the existing new_tx/tx_data/tx_busy handshake; toward each source it presents the same handshake, with a per-source busy.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- DATA_W, 8: byte width.
- IDLE_TIMEOUT, 255: cycles a grant may go without an accepted byte before it is revoked (≥2).
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- req  in  NUM_REQ  source i wants the transmitter; held for the whole message.
- req_valid  in  NUM_REQ  source i presents a byte (new_tx style).
- req_data  in  NUM_REQ*DATA_W  byte of source i in bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  byte presented with req_valid is the last of the message.
- req_busy  out  NUM_REQ  source i must not present bytes (tx_busy style).
- grant  out  NUM_REQ  one-hot current owner; all-zero when none.
- new_tx  out  1  one-cycle strobe to the UART tx.
- tx_data  out  DATA_W  byte to the UART tx; valid while new_tx is high.
- tx_busy  in  1  UART tx cannot accept a byte.

## Operation
- States: IDLE, GRANTED.
- Reset values:
  - state = IDLE, grant = 0, rr_ptr = 0, timer = 0.
  - new_tx = 0, tx_data = 0.
  - req_busy is all-ones, because it is derived from grant = 0.
- IDLE:
  - If any req bit is set, grant goes to the first set bit scanning cyclically from rr_ptr.
  - The owner index is registered and the state moves to GRANTED.
  - If no req bit is set, the state stays IDLE.
- Busy rule: req_busy[i] = !(grant[i] && !tx_busy && !new_tx).
  - Non-owners always see busy.
  - req_valid from a non-owner is ignored and the byte is dropped.
- Accept rule: a byte is accepted when req_valid[owner] && !req_busy[owner].
  - On accept, tx_data <= req_data[owner] and new_tx <= 1 for exactly one cycle.
  - On accept, timer <= 0.
- Timer: in GRANTED without an accept, timer increments and saturates. Its width is $clog2(IDLE_TIMEOUT+1).
- Release: grant clears, state returns to IDLE and rr_ptr <= (owner+1) mod NUM_REQ. Any of the following triggers it:
  - (a) accepted byte with req_last;
  - (b) req[owner] low in a cycle with no accept;
  - (c) timer == IDLE_TIMEOUT-1 with no accept.
- Simultaneous accept and req drop: the byte is sent; release happens only if req_last is high, otherwise on the next cycle via (b).
- Simultaneous accept and timeout: the accept wins and the timer clears.
- Reset mid-message: everything returns to reset values at once; any in-flight byte in new_tx/tx_data is discarded.

## Timing
- Grant latency: req rising before edge k gives grant high after edge k. The owner's req_busy can go low in the same cycle if tx_busy is low.
- Data latency: byte accepted at edge k gives new_tx/tx_data high for the cycle after edge k.
- new_tx forces req_busy high for one cycle. This covers the UART's one-cycle delay in raising tx_busy, so no byte is issued back-to-back.
- Release at edge k gives state IDLE after k. The next grant comes at edge k+1 at the earliest, so there is at least one cycle with grant = 0 between owners.
- The final new_tx of a message may overlap that IDLE cycle.
- Max throughput: one byte per 2 cycles when tx_busy stays low.

## Structure
- Shared package uart_arb_pkg holds:
  - state encodings IDLE = 1'b0, GRANTED = 1'b1;
  - DATA_W default 8;
  - the index-width function.
- Sub-module rr_pick (combinational):
  - inputs: req vector and rr_ptr;
  - outputs: one-hot pick and pick index.
- The FSM, timer and output registers stay in the top module.

## Test plan
- **Single requester:** NUM_REQ = 2; req[0] sends 14-byte "Hello World!\r\n" with tx_busy low; req_last on byte 14.
  - 14 new_tx pulses, 2 cycles apart, in order.
  - grant 01 then 00 after the last byte.
  - rr_ptr = 1.
- **Contention:** req[0] and req[1] both rise at cycle 0 after reset.
  - Source 0 is served first.
  - Source 1 is granted 2 cycles after source 0's last-byte accept.
  - The two sources' bytes never interleave on tx_data.
- **Round-robin fairness:** both requesters continuously re-request 3-byte messages.
  - Grants alternate 01, 10, 01, 10.
  - Exactly 3 new_tx per grant.
- **Backpressure:** tx_busy is held high for 20 cycles mid-message.
  - req_busy[owner] stays high for all 20 cycles.
  - No new_tx pulses, and no timeout, since 20 < 255.
  - The stream resumes without loss.
- **Stall timeout:** IDLE_TIMEOUT = 4; the owner holds req with no valid.
  - Grant revoked after 4 cycles in GRANTED.
  - The other pending requester is granted on the next edge.
- **Reset mid-message:** assert rst on the cycle new_tx is high.
  - new_tx, grant and tx_data go to 0 immediately.
  - After release, arbitration restarts from rr_ptr = 0.
